// File: rtl/uart_pkg.sv
// Shared UART definitions: frame levels, data width and FSM state encoding.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int   DATA_BITS   = 8;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd6,
`endif
      ST_STOP   = 3'd5
   } uart_state_e;

`ifdef UART_TX_PARITY_EN
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps on tick, clears on demand.
// pre_tick_o flags the cycle before tick so registered outputs can land on the last cycle.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr_i,
   output logic tick_o,
   output logic pre_tick_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o     = (cnt_q == CW'(CLKS_PER_BIT - 1));
   assign pre_tick_o = (cnt_q == CW'(CLKS_PER_BIT - 2));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: requests a byte on tx_start, then sends it 8N1 LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 115200
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tdata,
   output logic                 tdata_req,
   output logic                 uart_tx,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic [2:0]           dbg_state
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W        = $clog2(DATA_BITS);

   uart_state_e            state_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic [IDX_W-1:0]       bit_idx_q;
   logic                   uart_tx_q;
   logic                   tdata_req_q;
   logic                   tx_busy_q;
   logic                   tx_done_q;
`ifdef UART_TX_PARITY_EN
   logic                   parity_q;
`endif

   logic baud_clr;
   logic baud_tick;
   logic baud_pre_tick;

   // The counter idles at zero outside the bit states; every bit-state exit
   // happens on a tick, where the counter wraps, so each new state starts at 0.
   assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_REQ) || (state_q == ST_LOAD);

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CW           (CW)
   ) u_baud (
      .clk        (clk),
      .rstn       (rstn),
      .clr_i      (baud_clr),
      .tick_o     (baud_tick),
      .pre_tick_o (baud_pre_tick)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_idx_q   <= '0;
         uart_tx_q   <= IDLE_LEVEL;
         tdata_req_q <= 1'b0;
         tx_busy_q   <= 1'b0;
         tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         tdata_req_q <= 1'b0;
         tx_done_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               uart_tx_q <= IDLE_LEVEL;
               if (tx_start) begin
                  state_q     <= ST_REQ;
                  tdata_req_q <= 1'b1;
                  tx_busy_q   <= 1'b1;
               end
            end
            ST_REQ: begin
               state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               shift_q   <= tdata;
               bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
               parity_q  <= even_parity(tdata);
`endif
               uart_tx_q <= START_LEVEL;
               state_q   <= ST_START;
            end
            ST_START: begin
               if (baud_tick) begin
                  uart_tx_q <= shift_q[0];
                  state_q   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (baud_tick) begin
                  shift_q   <= shift_q >> 1;
                  bit_idx_q <= bit_idx_q + IDX_W'(1);
                  if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     uart_tx_q <= parity_q;
                     state_q   <= ST_PARITY;
`else
                     uart_tx_q <= STOP_LEVEL;
                     state_q   <= ST_STOP;
`endif
                  end else begin
                     uart_tx_q <= shift_q[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (baud_tick) begin
                  uart_tx_q <= STOP_LEVEL;
                  state_q   <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               // Raised one cycle early so the registered pulse sits on the last stop cycle.
               if (baud_pre_tick) begin
                  tx_done_q <= 1'b1;
               end
               if (baud_tick) begin
                  tx_busy_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: begin
               uart_tx_q <= IDLE_LEVEL;
               tx_busy_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign uart_tx   = uart_tx_q;
   assign tdata_req = tdata_req_q;
   assign tx_busy   = tx_busy_q;
   assign tx_done   = tx_done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomized scoreboard bench for uart_tx_engine with CLKS_PER_BIT = 10.
// Define UART_TX_PARITY_EN to check 8E1 frames instead of 8N1.
module tb_uart_tx_engine;
   import uart_pkg::*;

   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int F = NB * CPB;

   logic       clk;
   logic       rstn;
   logic       tx_start;
   logic [7:0] tdata;
   logic       tdata_req;
   logic       uart_tx;
   logic       tx_busy;
   logic       tx_done;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model state
   logic [NB-1:0] exp_q[$];
   int            exp_start_q[$];
   int            req_cyc  = -1;
   int            done_cyc = -1;
   int            b_lo     = -1;
   int            b_hi     = -1;
   int            busy_end = 0;

   uart_tx_engine #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .tx_start  (tx_start),
      .tdata     (tdata),
      .tdata_req (tdata_req),
      .uart_tx   (uart_tx),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic flag_unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d: event with nothing expected", name, cyc);
   endtask

   // Line levels of a whole frame, slot 0 = start bit.
   function automatic logic [NB-1:0] model_frame(input logic [7:0] b);
      logic [NB-1:0] f;
      f = '0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ($countones(b) % 2) == 1;
`endif
      f[NB-1] = 1'b1;
      return f;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Caller is at a negedge; tx_start is held for exactly one rising edge.
   task automatic pulse_start(input logic [7:0] b);
      tx_start = 1'b1;
      if (cyc >= busy_end) begin
         tdata    = b;
         exp_q.push_back(model_frame(b));
         exp_start_q.push_back(cyc + 3);
         req_cyc  = cyc + 1;
         b_lo     = cyc + 1;
         b_hi     = cyc + 2 + F;
         done_cyc = cyc + 2 + F;
         busy_end = cyc + 3 + F;
      end
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_start_q.delete();
      req_cyc  = -1;
      done_cyc = -1;
      b_lo     = -1;
      b_hi     = -1;
      busy_end = 0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic          line_prev;
      logic          mon_active;
      int            mon_cnt;
      logic [NB-1:0] got;
      logic [NB-1:0] exp_f;
      line_prev  = 1'b1;
      mon_active = 1'b0;
      mon_cnt    = 0;
      got        = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            mon_active = 1'b0;
            line_prev  = 1'b1;
         end else begin
            check("tx_busy", int'(tx_busy), int'((cyc >= b_lo) && (cyc <= b_hi)));
            check("tx_done", int'(tx_done), int'(cyc == done_cyc));
            check("tdata_req", int'(tdata_req), int'(cyc == req_cyc));
            if (!mon_active) begin
               if (line_prev && !uart_tx) begin
                  mon_active = 1'b1;
                  mon_cnt    = 0;
                  got        = '0;
                  if (exp_start_q.size() == 0) flag_unexpected("start_bit");
                  else check("start_latency", cyc, exp_start_q.pop_front());
               end
            end else begin
               mon_cnt++;
            end
            if (mon_active) begin
               if (mon_cnt % CPB == CPB / 2) got[mon_cnt / CPB] = uart_tx;
               if (mon_cnt == F - 1) begin
                  if (exp_q.size() == 0) flag_unexpected("frame");
                  else begin
                     exp_f = exp_q.pop_front();
                     check("frame_bits", int'(got), int'(exp_f));
                  end
                  mon_active = 1'b0;
               end
            end
            line_prev = uart_tx;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin : watchdog
      repeat (30000) @(posedge clk);
      checks++;
      errors++;
      $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int c;
      rstn     = 1'b0;
      tx_start = 1'b0;
      tdata    = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_uart_tx", int'(uart_tx), 1);
      check("rst_tdata_req", int'(tdata_req), 0);
      check("rst_tx_busy", int'(tx_busy), 0);
      check("rst_tx_done", int'(tx_done), 0);
      check("rst_state", int'(dbg_state), int'(ST_IDLE));
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // single byte
      pulse_start(8'hA5);
      wait_until(busy_end + 2);

      // busy rejection
      c = cyc;
      pulse_start(8'h5A);
      wait_until(c + 20);
      pulse_start(8'hC3);
      wait_until(c + 50);
      pulse_start(8'h0F);
      wait_until(busy_end + 2);

      // back-to-back: start on the tx_done cycle is ignored, next cycle is taken
      pulse_start(8'h96);
      wait_until(done_cyc);
      pulse_start(8'hE7);
      pulse_start(8'h00);
      wait_until(busy_end + 2);

      // data stability
      c = cyc;
      pulse_start(8'h3C);
      wait_until(c + 30);
      tdata = 8'hFF;
      wait_until(busy_end + 2);

      // reset in the middle of data bit 4
      c = cyc;
      pulse_start(8'h6B);
      wait_until(c + 3 + 5 * CPB + CPB / 2);
      rstn = 1'b0;
      model_reset();
      #1;
      check("midrst_uart_tx", int'(uart_tx), 1);
      check("midrst_tx_busy", int'(tx_busy), 0);
      check("midrst_state", int'(dbg_state), int'(ST_IDLE));
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      pulse_start(8'h81);
      wait_until(busy_end + 2);

      // parity examples (plain frames when parity is disabled)
      pulse_start(8'h07);
      wait_until(busy_end);
      pulse_start(8'h03);
      wait_until(busy_end + 2);

      // random bytes and gaps, some landing inside busy frames
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, F + 15)) @(negedge clk);
         pulse_start(8'($urandom_range(0, 255)));
      end
      wait_until(busy_end + 3);

      check("frames_outstanding", exp_q.size(), 0);
      check("starts_outstanding", exp_start_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
